alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 118 +++++++++++
 tb/tb_alu_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational 8-bit ALU.
// Each accepted op runs IDLE -> EXEC (ALU sampled) -> RESP (held until consumed).
module alu_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_cin,
    input  logic [3:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_cin,
    input  logic [3:0]        req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_cout,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_cout,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_c_in,
    output logic [2:0]        alu_ctrl,
    output logic              alu_mode,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_c_out,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            r_state, w_next;
    logic              r_prio, r_gnt;
    logic [DATA_W-1:0] r_a, r_b, r_res;
    logic              r_cin, r_cout;
    logic [3:0]        r_op;
    logic              w_gnt, w_accept, w_rsp_done, w_drive;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        w_rsp_done = 1'b0;
        // Contention goes to the pointer; a lone requester wins outright.
        w_gnt      = (req0_valid && req1_valid) ? r_prio : req1_valid;
        case (r_state)
            IDLE: begin
                req0_ready = req0_valid && !w_gnt;
                req1_ready = req1_valid &&  w_gnt;
                if (req0_ready || req1_ready) w_next = EXEC;
            end
            EXEC: w_next = RESP;
            RESP: begin
                w_rsp_done = r_gnt ? rsp1_ready : rsp0_ready;
                if (w_rsp_done) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_accept = req0_ready || req1_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= 1'b0;
            r_gnt  <= 1'b0;
            r_a    <= '0;
            r_b    <= '0;
            r_cin  <= 1'b0;
            r_op   <= '0;
            r_res  <= '0;
            r_cout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_gnt <= w_gnt;
                r_a   <= w_gnt ? req1_a   : req0_a;
                r_b   <= w_gnt ? req1_b   : req0_b;
                r_cin <= w_gnt ? req1_cin : req0_cin;
                r_op  <= w_gnt ? req1_op  : req0_op;
            end
            if (r_state == EXEC) begin
                r_res  <= alu_out;
                r_cout <= alu_c_out;
            end
            if (w_rsp_done) r_prio <= ~r_gnt;
        end
    end

    // Outputs are forced low while reset is held so an aborted op never shows.
    assign w_drive    = !rst && (r_state != IDLE);
    assign busy       = w_drive;
    assign alu_a      = w_drive ? r_a       : '0;
    assign alu_b      = w_drive ? r_b       : '0;
    assign alu_c_in   = w_drive && r_cin;
    assign alu_ctrl   = w_drive ? r_op[2:0] : 3'b000;
    assign alu_mode   = w_drive && r_op[3];

    assign rsp0_valid = !rst && (r_state == RESP) && !r_gnt;
    assign rsp1_valid = !rst && (r_state == RESP) &&  r_gnt;
    assign rsp0_data  = rsp0_valid ? r_res : '0;
    assign rsp1_data  = rsp1_valid ? r_res : '0;
    assign rsp0_cout  = rsp0_valid && r_cout;
    assign rsp1_cout  = rsp1_valid && r_cout;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: table of directed transactions, hand-written reset
// corner cases and randomized traffic against a transaction-level model.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       req0_cin = 1'b0, req1_cin = 1'b0;
    logic [3:0] req0_op = '0, req1_op = '0;
    logic       rsp0_valid, rsp1_valid;
    logic       rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [7:0] rsp0_data, rsp1_data;
    logic       rsp0_cout, rsp1_cout;
    logic [7:0] alu_a, alu_b, alu_out;
    logic       alu_c_in, alu_mode, alu_c_out;
    logic [2:0] alu_ctrl;
    logic       busy;

    int checks = 0;
    int errors = 0;
    logic m_prio = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_cin(req0_cin), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_cin(req1_cin), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_cout(rsp0_cout),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_cout(rsp1_cout),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c_in(alu_c_in), .alu_ctrl(alu_ctrl), .alu_mode(alu_mode),
        .alu_out(alu_out), .alu_c_out(alu_c_out), .busy(busy)
    );

    // Shared ALU: mode 1 = add (ctrl[0] inverts b), mode 0 = logic ops.
    function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic cin, input logic [3:0] op);
        logic [8:0] s;
        logic [7:0] r;
        if (op[3]) begin
            s = {1'b0, a} + {1'b0, (op[0] ? ~b : b)} + {8'h00, cin};
            return s;
        end
        case (op[2:0])
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = a ^ b;
            3'b011:  r = ~(a | b);
            3'b100:  r = ~(a & b);
            3'b101:  r = ~(a ^ b);
            3'b110:  r = ~a;
            default: r = a;
        endcase
        return {(op[2:0] == 3'b111) ? a[0] : 1'b0, r};
    endfunction

    assign {alu_c_out, alu_out} = alu_fn(alu_a, alu_b, alu_c_in, {alu_mode, alu_ctrl});

    typedef struct {
        logic       v0, v1;
        logic [7:0] a0, b0;
        logic       cin0;
        logic [3:0] op0;
        logic [7:0] a1, b1;
        logic       cin1;
        logic [3:0] op1;
        int         stall;
        logic       g;
        logic [7:0] d;
        logic       c;
    } txn_t;

    txn_t tbl [8];

    function automatic logic [63:0] obs();
        return 64'({busy, req0_ready, req1_ready, rsp0_valid, rsp0_data, rsp0_cout,
                    rsp1_valid, rsp1_data, rsp1_cout, alu_mode, alu_ctrl, alu_c_in, alu_a, alu_b});
    endfunction

    function automatic logic [63:0] mk(input logic bz, input logic r0, input logic r1,
                                       input logic v0, input logic [7:0] d0, input logic c0,
                                       input logic v1, input logic [7:0] d1, input logic c1,
                                       input logic md, input logic [2:0] ct, input logic ci,
                                       input logic [7:0] a, input logic [7:0] b);
        return 64'({bz, r0, r1, v0, d0, c0, v1, d1, c1, md, ct, ci, a, b});
    endfunction

    function automatic logic [63:0] zero_vec();
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000, 1'b0, 8'h00, 8'h00);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: grant from the alternating pointer, result from the ALU rules.
    function automatic txn_t predict(input txn_t t);
        txn_t       r;
        logic [8:0] res;
        r   = t;
        r.g = (t.v0 && t.v1) ? m_prio : t.v1;
        res = r.g ? alu_fn(t.a1, t.b1, t.cin1, t.op1) : alu_fn(t.a0, t.b0, t.cin0, t.op0);
        r.d = res[7:0];
        r.c = res[8];
        return r;
    endfunction

    task automatic run_txn(input txn_t t, input string tag);
        logic [7:0]  a, b;
        logic        cin;
        logic [3:0]  op;
        logic [63:0] rv;
        int          n;
        @(negedge clk);
        req0_valid = t.v0; req0_a = t.a0; req0_b = t.b0; req0_cin = t.cin0; req0_op = t.op0;
        req1_valid = t.v1; req1_a = t.a1; req1_b = t.b1; req1_cin = t.cin1; req1_op = t.op1;
        rsp0_ready = (t.stall == 0);
        rsp1_ready = (t.stall == 0);
        #1;
        n = 0;
        while (!(req0_ready || req1_ready) && n < 8) begin
            @(negedge clk); #1; n++;
        end
        chk({tag, " grant"}, 64'({req0_ready, req1_ready}), 64'({~t.g, t.g}));
        if (!(req0_ready || req1_ready)) begin
            req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
            return;
        end
        a   = t.g ? t.a1   : t.a0;
        b   = t.g ? t.b1   : t.b0;
        cin = t.g ? t.cin1 : t.cin0;
        op  = t.g ? t.op1  : t.op0;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk({tag, " exec"}, obs(),
            mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, op[3], op[2:0], cin, a, b));
        @(negedge clk); #1;
        rv = mk(1'b1, 1'b0, 1'b0, ~t.g, t.g ? 8'h00 : t.d, ~t.g & t.c,
                t.g, t.g ? t.d : 8'h00, t.g & t.c, op[3], op[2:0], cin, a, b);
        chk({tag, " resp"}, obs(), rv);
        // Back-pressure: other traffic waiting must not be accepted.
        for (int i = 0; i < t.stall; i++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            @(negedge clk); #1;
            chk({tag, " stall"}, obs(), rv);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        @(negedge clk); #1;
        chk({tag, " idle"}, obs(), zero_vec());
        m_prio = ~t.g;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        txn_t t;
        logic [1:0] v;
        tbl[0] = '{1'b1, 1'b0, 8'hF0, 8'h20, 1'b1, 4'b1000, 8'h00, 8'h00, 1'b0, 4'b0000, 0, 1'b0, 8'h11, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 4'b0000, 8'h0F, 8'hF0, 1'b0, 4'b0011, 0, 1'b1, 8'h00, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 8'h05, 8'h03, 1'b1, 4'b1001, 8'h03, 8'h05, 1'b1, 4'b1001, 0, 1'b0, 8'h02, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 8'h05, 8'h03, 1'b1, 4'b1001, 8'h03, 8'h05, 1'b1, 4'b1001, 0, 1'b1, 8'hFE, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 8'hAA, 8'h0F, 1'b0, 4'b0000, 8'h55, 8'h0F, 1'b0, 4'b0111, 0, 1'b0, 8'h0A, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 8'hAA, 8'h0F, 1'b0, 4'b0000, 8'h55, 8'h0F, 1'b0, 4'b0111, 5, 1'b1, 8'h55, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 8'hFF, 8'h01, 1'b0, 4'b1000, 8'h00, 8'h00, 1'b0, 4'b0000, 0, 1'b0, 8'h00, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 4'b0000, 8'h3C, 8'h0F, 1'b0, 4'b0010, 0, 1'b1, 8'h33, 1'b0};

        @(negedge clk); @(negedge clk); #1;
        chk("reset_held", obs(), zero_vec());
        @(negedge clk); rst = 1'b0; #1;
        chk("reset_released", obs(), zero_vec());

        for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

        // Reset during EXEC: pointer left at 1 first so its return to 0 is visible.
        run_txn(tbl[0], "pre_rst");
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 8'h12; req1_b = 8'h34; req1_cin = 1'b0; req1_op = 4'b1000;
        #1;
        chk("rst_op_grant", 64'({req0_ready, req1_ready}), 64'(2'b01));
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0; rst = 1'b1; #1;
        chk("rst_in_exec", obs(), zero_vec());
        @(negedge clk); rst = 1'b0;
        m_prio = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("rst_no_rsp", obs(), zero_vec());
        end
        t = '{1'b1, 1'b1, 8'h40, 8'h02, 1'b0, 4'b1000, 8'h77, 8'h11, 1'b1, 4'b1001, 0, 1'b0, 8'h00, 1'b0};
        run_txn(predict(t), "post_rst");

        for (int i = 0; i < 200; i++) begin
            v       = 2'($urandom_range(1, 3));
            t.v0    = v[0];        t.v1    = v[1];
            t.a0    = 8'($urandom); t.b0   = 8'($urandom);
            t.cin0  = 1'($urandom); t.op0  = 4'($urandom);
            t.a1    = 8'($urandom); t.b1   = 8'($urandom);
            t.cin1  = 1'($urandom); t.op1  = 4'($urandom);
            t.stall = $urandom_range(0, 2);
            run_txn(predict(t), $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
